// File: rtl/dino_pkg.sv
// Shared types and helpers for the dinosaur runner game controller:
// game state enum, packed 4-digit BCD type, default jump length,
// the jump parabola and a digit-wise BCD magnitude compare.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Four BCD digits, [3] is the thousands digit.
  typedef logic [3:0][3:0] bcd4_t;

  localparam int DEF_JUMP_FRAMES = 60;

  // Lift above ground for frame t of the arc: (t*frames - t*t)/6.
  // A 12-bit unsigned intermediate is wide enough for frames <= 63.
  function automatic logic [7:0] jump_height(input logic [5:0] t, input logic [11:0] frames);
    logic [11:0] lin;
    logic [11:0] sq;
    logic [11:0] diff;
    lin  = {6'd0, t} * frames;
    sq   = {6'd0, t} * {6'd0, t};
    diff = lin - sq;
    jump_height = 8'(diff / 12'd6);
  endfunction

  // True when a > b, deciding on the most significant differing digit.
  function automatic logic bcd_gt(input bcd4_t a, input bcd4_t b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        gt      = (a[i] > b[i]);
        decided = 1'b1;
      end else begin
        gt      = gt;
        decided = decided;
      end
    end
    bcd_gt = gt;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Saturating 4-digit BCD incrementer. Increments on en, clears on clear,
// sticks at 9999. hundreds_roll flags an increment that rolls the low two
// digits from 99 to 00 (used to step the speed level).
module bcd_counter4
  import dino_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  en,
  output bcd4_t count,
  output logic  hundreds_roll
);

  bcd4_t value;
  bcd4_t value_inc;
  logic  carry;
  logic  full;

  assign count = value;

  // Ripple a +1 through the digits and flag saturation / hundreds roll.
  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    full      = (value == 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i] == 4'd9) begin
          value_inc[i] = 4'd0;
          carry        = 1'b1;
        end else begin
          value_inc[i] = value[i] + 4'd1;
          carry        = 1'b0;
        end
      end else begin
        value_inc[i] = value[i];
      end
    end
    hundreds_roll = en & ~full & (value[1] == 4'd9) & (value[0] == 4'd9);
  end

  // Count register: clear wins over increment, saturated value holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 16'h0000;
    end else if (clear) begin
      value <= 16'h0000;
    end else if (en && !full) begin
      value <= value_inc;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Central game controller: IDLE/RUN/OVER state machine, per-frame jump
// trajectory, BCD score and speed level. All outputs are registered.
// Optional feature macro: DINO_HIGHSCORE_EN keeps a best-score register;
// without it high_score is tied to 0.
// A collision or jump press seen on a tick cycle is kept for the next tick
// rather than being lost to that tick's clear.
module game_sequencer
  import dino_pkg::*;
#(
  parameter int JUMP_FRAMES = DEF_JUMP_FRAMES,
  parameter int SCORE_DIV   = 6,
  parameter int MAX_LEVEL   = 7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fresh,
  input  logic        START,
  input  logic        button_jump,
  input  logic        collision,
  output logic        game_status,
  output logic        crashed,
  output logic        jumping,
  output logic [5:0]  jump_time,
  output logic [7:0]  height,
  output logic [15:0] score,
  output logic [2:0]  level,
  output logic [15:0] high_score
);

  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  game_state_t      state;
  game_state_t      state_next;
  logic             game_status_next;
  logic             crashed_next;
  logic             fresh_d;
  logic             tick;
  logic             run_tick;
  logic             advance;
  logic             crash;
  logic             enter_run;
  logic             coll_latch;
  logic             jump_req;
  logic [DIV_W-1:0] div;
  logic             score_en;
  logic             hundreds_roll;
  bcd4_t            score_bcd;

  assign tick      = fresh_d & ~fresh;
  assign run_tick  = (state == RUN) & tick;
  assign crash     = run_tick & coll_latch;
  assign advance   = run_tick & ~coll_latch;
  assign enter_run = (state != RUN) & (state_next == RUN);
  assign score_en  = advance & (div == DIV_W'(SCORE_DIV - 1));
  assign score     = score_bcd;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: START leaves IDLE/OVER, a latched collision ends RUN on a tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = RUN;  else state_next = IDLE;
      RUN:     if (crash) state_next = OVER; else state_next = RUN;
      OVER:    if (START) state_next = RUN;  else state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the status flags can be registered.
  always_comb begin
    game_status_next = (state_next == RUN);
    crashed_next     = (state_next == OVER);
  end

  // Registered status flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      game_status <= 1'b0;
      crashed     <= 1'b0;
    end else begin
      game_status <= game_status_next;
      crashed     <= crashed_next;
    end
  end

  // Delayed frame strobe for falling-edge tick detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fresh_d <= 1'b0;
    end else begin
      fresh_d <= fresh;
    end
  end

  // Collision and jump request latches, live only while running.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coll_latch <= 1'b0;
      jump_req   <= 1'b0;
    end else if (enter_run) begin
      coll_latch <= 1'b0;
      jump_req   <= 1'b0;
    end else if (state == RUN) begin
      coll_latch <= collision | (coll_latch & ~tick);
      jump_req   <= button_jump | (jump_req & ~tick);
    end else begin
      coll_latch <= 1'b0;
      jump_req   <= 1'b0;
    end
  end

  // Frame divider between score points.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div <= '0;
    end else if (enter_run) begin
      div <= '0;
    end else if (advance) begin
      div <= score_en ? '0 : div + DIV_W'(1);
    end else begin
      div <= div;
    end
  end

  // Jump arc sequencing; presses during an arc are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      jumping   <= 1'b0;
      jump_time <= 6'd0;
    end else if (enter_run) begin
      jumping   <= 1'b0;
      jump_time <= 6'd0;
    end else if (advance) begin
      if (jumping && (jump_time == 6'(JUMP_FRAMES))) begin
        jumping   <= 1'b0;
        jump_time <= 6'd0;
      end else if (jumping) begin
        jumping   <= 1'b1;
        jump_time <= jump_time + 6'd1;
      end else if (jump_req) begin
        jumping   <= 1'b1;
        jump_time <= 6'd1;
      end else begin
        jumping   <= jumping;
        jump_time <= jump_time;
      end
    end else begin
      jumping   <= jumping;
      jump_time <= jump_time;
    end
  end

  // Height follows jump_time one cycle later, so a frozen arc freezes height too.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      height <= 8'd0;
    end else begin
      height <= jump_height(jump_time, 12'(JUMP_FRAMES));
    end
  end

  // Speed level steps on every hundred points, saturating.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      level <= 3'd0;
    end else if (enter_run) begin
      level <= 3'd0;
    end else if (score_en && hundreds_roll && (level != 3'(MAX_LEVEL))) begin
      level <= level + 3'd1;
    end else begin
      level <= level;
    end
  end

  bcd_counter4 u_score (
    .clk           (CLK),
    .rst           (RESET),
    .clear         (enter_run),
    .en            (score_en),
    .count         (score_bcd),
    .hundreds_roll (hundreds_roll)
  );

`ifdef DINO_HIGHSCORE_EN
  bcd4_t best;

  // Best score captured at the crash, survives restarts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      best <= 16'h0000;
    end else if (crash && bcd_gt(score_bcd, best)) begin
      best <= score_bcd;
    end else begin
      best <= best;
    end
  end

  assign high_score = best;
`else
  assign high_score = 16'h0000;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a behavioural reference model
// pushes expected outputs to a scoreboard queue each clock; the queue is
// popped and compared half a cycle later. Directed checks cover the
// documented corner points (jump arc, crash freeze, saturation, reset).
module tb_game_sequencer;

`ifdef DINO_HIGHSCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        fresh, START, button_jump, collision;
  logic        game_status, crashed, jumping;
  logic [5:0]  jump_time;
  logic [7:0]  height;
  logic [15:0] score, level_pad, high_score;
  logic [2:0]  level;

  game_sequencer dut (
    .CLK(CLK), .RESET(RESET), .fresh(fresh), .START(START),
    .button_jump(button_jump), .collision(collision),
    .game_status(game_status), .crashed(crashed), .jumping(jumping),
    .jump_time(jump_time), .height(height), .score(score),
    .level(level), .high_score(high_score)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        gs, cr, jp;
    logic [5:0]  jt;
    logic [7:0]  h;
    logic [15:0] sc;
    logic [2:0]  lv;
    logic [15:0] hs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference model state
  int m_st, m_fd, m_coll, m_req, m_jmp, m_jt, m_h, m_sc, m_lv, m_div, m_hs;
  logic [15:0] frozen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int height_of(input int t);
    return (t * 60 - t * t) / 6;
  endfunction

  task automatic model_reset();
    m_st = 0; m_fd = 0; m_coll = 0; m_req = 0; m_jmp = 0; m_jt = 0;
    m_h = 0; m_sc = 0; m_lv = 0; m_div = 0; m_hs = 0;
  endtask

  task automatic model_step(input bit f, input bit s, input bit bj, input bit co);
    bit tk;
    int h_next;
    tk     = (m_fd == 1) && !f;
    h_next = height_of(m_jt);
    if (m_st == 0 || m_st == 2) begin
      if (s) begin
        m_st = 1; m_sc = 0; m_lv = 0; m_div = 0;
        m_jmp = 0; m_jt = 0; m_coll = 0; m_req = 0;
      end
    end else if (tk) begin
      if (m_coll != 0) begin
        m_st = 2;
        if (m_sc > m_hs) m_hs = m_sc;
      end else begin
        if (m_jmp != 0 && m_jt == 60) begin m_jmp = 0; m_jt = 0; end
        else if (m_jmp != 0) m_jt++;
        else if (m_req != 0) begin m_jmp = 1; m_jt = 1; end
        if (m_div == 5) begin
          m_div = 0;
          if (m_sc < 9999) begin
            m_sc++;
            if ((m_sc % 100) == 0 && m_lv < 7) m_lv++;
          end
        end else begin
          m_div++;
        end
      end
      m_coll = int'(co); m_req = int'(bj);
    end else begin
      m_coll = m_coll | int'(co); m_req = m_req | int'(bj);
    end
    m_h  = h_next;
    m_fd = int'(f);
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.gs = (m_st == 1);
    e.cr = (m_st == 2);
    e.jp = (m_jmp != 0);
    e.jt = 6'(m_jt);
    e.h  = 8'(m_h);
    e.sc = to_bcd(m_sc);
    e.lv = 3'(m_lv);
    e.hs = HS_EN ? to_bcd(m_hs) : 16'h0000;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check_eq("sb_status",  32'(game_status), 32'(e.gs));
      check_eq("sb_crashed", 32'(crashed),     32'(e.cr));
      check_eq("sb_jumping", 32'(jumping),     32'(e.jp));
      check_eq("sb_jtime",   32'(jump_time),   32'(e.jt));
      check_eq("sb_height",  32'(height),      32'(e.h));
      check_eq("sb_score",   32'(score),       32'(e.sc));
      check_eq("sb_level",   32'(level),       32'(e.lv));
      check_eq("sb_hiscore", 32'(high_score),  32'(e.hs));
    end
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task cycle(input bit f, input bit s, input bit bj, input bit co);
    fresh = f; START = s; button_jump = bj; collision = co;
    @(posedge CLK);
    model_step(f, s, bj, co);
    q.push_back(expected());
    @(negedge CLK);
    compare_out();
  endtask

  // one frame: fresh high (requests here), falling edge tick, settle cycle
  task frame(input bit s, input bit bj, input bit co);
    cycle(1'b1, s, bj, co);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_status"},  32'(game_status), 32'd0);
    check_eq({tag, "_crashed"}, 32'(crashed),     32'd0);
    check_eq({tag, "_jumping"}, 32'(jumping),     32'd0);
    check_eq({tag, "_jtime"},   32'(jump_time),   32'd0);
    check_eq({tag, "_height"},  32'(height),      32'd0);
    check_eq({tag, "_score"},   32'(score),       32'd0);
    check_eq({tag, "_level"},   32'(level),       32'd0);
    check_eq({tag, "_hiscore"}, 32'(high_score),  32'd0);
  endtask

  initial begin
    RESET = 1'b1; fresh = 1'b0; START = 1'b0; button_jump = 1'b0; collision = 1'b0;
    level_pad = 16'h0000;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RESET = 1'b0;

    // start: status one cycle later, score and level clear
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("start_status", 32'(game_status), 32'd1);
    check_eq("start_score",  32'(score),       32'd0);
    check_eq("start_level",  32'(level),       32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // full jump arc with an ignored second press at t=20
    frame(1'b0, 1'b1, 1'b0);
    check_eq("arc_t1", 32'(jump_time), 32'd1);
    check_eq("arc_h1", 32'(height),    32'd9);
    for (int k = 2; k <= 60; k++) begin
      frame(1'b0, (k == 21), 1'b0);
      check_eq("arc_jtime",   32'(jump_time), 32'(k));
      check_eq("arc_jumping", 32'(jumping),   32'd1);
      if (k == 30) check_eq("arc_peak", 32'(height), 32'd150);
      if (k == 60) check_eq("arc_land", 32'(height), 32'd0);
    end
    frame(1'b0, 1'b0, 1'b0);
    check_eq("arc_end_jtime",   32'(jump_time), 32'd0);
    check_eq("arc_end_jumping", 32'(jumping),   32'd0);
    frame(1'b0, 1'b0, 1'b0);
    check_eq("second_press_dropped", 32'(jumping), 32'd0);

    // crash mid-jump at t=25 freezes the arc and the score
    frame(1'b0, 1'b1, 1'b0);
    repeat (24) frame(1'b0, 1'b0, 1'b0);
    check_eq("pre_crash_jtime", 32'(jump_time), 32'd25);
    frozen = to_bcd(m_sc);
    frame(1'b0, 1'b0, 1'b1);
    check_eq("crash_flag",   32'(crashed),     32'd1);
    check_eq("crash_status", 32'(game_status), 32'd0);
    check_eq("crash_jtime",  32'(jump_time),   32'd25);
    check_eq("crash_score",  32'(score),       32'(frozen));
    repeat (3) frame(1'b0, 1'b0, 1'b0);
    check_eq("over_jtime",  32'(jump_time), 32'd25);
    check_eq("over_height", 32'(height),    32'd145);
    check_eq("over_score",  32'(score),     32'(frozen));
    frame(1'b1, 1'b0, 1'b0);
    check_eq("restart_status", 32'(game_status), 32'd1);
    check_eq("restart_jtime",  32'(jump_time),   32'd0);
    check_eq("restart_height", 32'(height),      32'd0);
    check_eq("restart_score",  32'(score),       32'd0);
    check_eq("restart_level",  32'(level),       32'd0);

    // 600 ticks from restart: 100 points, level 1; then level saturates
    repeat (599) frame(1'b0, 1'b0, 1'b0);
    check_eq("score_100", 32'(score), 32'h0100);
    check_eq("level_1",   32'(level), 32'd1);
    repeat (4200) frame(1'b0, 1'b0, 1'b0);
    check_eq("score_800", 32'(score), 32'h0800);
    check_eq("level_sat", 32'(level), 32'd7);

    // score saturation at 9999
    force dut.u_score.value = 16'h9998;
    m_sc = 9998;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    release dut.u_score.value;
    repeat (12) frame(1'b0, 1'b0, 1'b0);
    check_eq("score_sat", 32'(score), 32'h9999);
    check_eq("level_hold", 32'(level), 32'd7);

    // collision and a pending jump on the same tick: crash wins
    frame(1'b0, 1'b1, 1'b1);
    check_eq("coljump_crash",   32'(crashed), 32'd1);
    check_eq("coljump_nojump",  32'(jumping), 32'd0);
    check_eq("coljump_score",   32'(score),   32'h9999);

    // START while running has no effect
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    check_eq("start_in_run_status", 32'(game_status), 32'd1);
    check_eq("start_in_run_score",  32'(score),       32'd0);

    // asynchronous reset in the middle of a jump
    frame(1'b0, 1'b1, 1'b0);
    repeat (5) frame(1'b0, 1'b0, 1'b0);
    check_eq("pre_reset_jtime", 32'(jump_time), 32'd6);
    #2 RESET = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    frame(1'b0, 1'b0, 1'b0);
    check_eq("post_reset_idle",  32'(game_status), 32'd0);
    check_eq("post_reset_score", 32'(score),       32'd0);

    // best score: crash at 0042 then at 0017
    frame(1'b1, 1'b0, 1'b0);
    repeat (251) frame(1'b0, 1'b0, 1'b0);
    check_eq("hs_score_42", 32'(score), 32'h0042);
    frame(1'b0, 1'b0, 1'b1);
    check_eq("hs_crash_42", 32'(crashed), 32'd1);
    check_eq("hs_after_42", 32'(high_score), HS_EN ? 32'h0042 : 32'd0);
    frame(1'b1, 1'b0, 1'b0);
    repeat (101) frame(1'b0, 1'b0, 1'b0);
    check_eq("hs_score_17", 32'(score), 32'h0017);
    frame(1'b0, 1'b0, 1'b1);
    check_eq("hs_after_17", 32'(high_score), HS_EN ? 32'h0042 : 32'd0);
    check_eq("hs_pad", 32'(level_pad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central game controller for the dinosaur runner. Owns the IDLE/RUN/OVER state machine that drives `game_status`, sequences the jump trajectory frame by frame, and keeps the BCD score and speed level. Sits between the button/collision inputs and the sprite, obstacle and score renderers, all of which consume its registered outputs.

## Interface
- `JUMP_FRAMES`, 60: frames per jump arc; also the parabola constant.
- `SCORE_DIV`, 6: frame ticks per score point.
- `MAX_LEVEL`, 7: saturation value of `level`.
- `CLK` in 1: system clock, the only clock.
- `RESET` in 1: asynchronous, active-high reset.
- `fresh` in 1: frame-refresh strobe, level signal; each falling edge is one frame tick.
- `START` in 1: start/restart request, level.
- `button_jump` in 1: jump request, level.
- `collision` in 1: pixel-overlap flag from the renderers; any cycle may assert it.
- `game_status` out 1: 1 while in RUN.
- `crashed` out 1: 1 while in OVER.
- `jumping` out 1: jump arc in progress.
- `jump_time` out 6: frame index within the arc, 0..JUMP_FRAMES.
- `height` out 8: dino lift in pixels above ground.
- `score` out 16: four BCD digits.
- `level` out 3: speed level, 0..MAX_LEVEL.
- `high_score` out 16: best BCD score. Tied to 0 when the feature is compiled out.

## Operation
- Tick detection: `fresh_d` register; `tick = fresh_d & ~fresh`. All game updates happen only on tick cycles, except the START transitions and the request and collision latches.
- FSM, reset state IDLE:
  - IDLE, START=1 → RUN.
  - RUN, tick with `coll_latch`=1 → OVER.
  - OVER, START=1 → RUN.
  - START in RUN is ignored.
  - Entering RUN clears score, level, frame divider, jump state, `coll_latch` and `jump_req`.
- `coll_latch`: set by `collision` in RUN; cleared on each tick and on entry to RUN.
- `jump_req`: set by `button_jump` in RUN; cleared on every RUN tick, whether or not it was consumed.
- Jump update, on RUN ticks without a crash:
  - If `jumping` and `jump_time == JUMP_FRAMES`: `jump_time` ← 0, `jumping` ← 0.
  - Else if `jumping`: `jump_time` increments.
  - Else if `jump_req`: `jumping` ← 1, `jump_time` ← 1.
  - Requests made while jumping are dropped.
- `height = (t*JUMP_FRAMES − t*t)/6`, with t = `jump_time`.
  - Intermediate is 12 bits unsigned; integer truncation.
  - Peak is 150 at t=30; t=1 gives 9; t=0 and t=60 give 0.
  - Registered one cycle after `jump_time`.
- Score, on RUN ticks without a crash:
  - The divider counts 0..SCORE_DIV−1; at wrap, `score` increments in BCD.
  - `score` saturates at 9999.
  - When the low two digits roll over to 00, `level` increments, saturating at MAX_LEVEL.
- OVER freezes `score`, `level`, `jump_time` and `height`, so the dino stays mid-air. IDLE holds all of them at 0.
- Crash precedence: a collision tick goes to OVER and suppresses the jump and score updates for that tick.

## Timing
- Reset values: state IDLE; every output 0; `fresh_d`, latches and divider 0. `high_score` is also 0.
- Frame tick to `jump_time`/`score`/`level`/`game_status`/`crashed`: 1 cycle (registered on the tick cycle).
- Frame tick to `height`: 2 cycles.
- START to `game_status`: 1 cycle.
- `button_jump` needs to be high for ≥1 cycle within a frame to register.
- Asynchronous RESET during a jump or in OVER returns to IDLE immediately. The first tick after release produces no update, because IDLE ignores ticks.

## Configuration
- `DINO_HIGHSCORE_EN` defined:
  - `high_score` updates on the RUN→OVER transition if `score > high_score` (BCD compare, digit-wise MSB first).
  - It survives restarts; only RESET clears it.
- Not defined: no register; `high_score` is constant 0.

## Structure
- Package `dino_pkg` holds:
  - the state enum `game_state_t` {IDLE, RUN, OVER}
  - `bcd4_t` (4×4-bit)
  - `JUMP_FRAMES` default
  - function `jump_height(t)`
- Sub-module `bcd_counter4`: saturating 4-digit BCD incrementer with enable, clear, and a `hundreds_roll` output that drives `level`.

## Test plan
- Reset, then START pulse → `game_status`=1 next cycle, `score`=0, `level`=0.
- RUN, `button_jump` high 1 cycle, then 61 ticks → `jump_time` 1..60 then 0. `height` hits 9 at t=1, 150 at t=30, 0 at t=60. A second press at t=20 is ignored.
- RUN for 600 ticks → `score`=0100, `level`=1. Force score 9998 then 12 ticks → holds 9999, `level` ≤ 7.
- `collision` pulse mid-jump at t=25 → next tick: OVER, `crashed`=1, `jump_time`=25 frozen, `score` frozen. START → RUN with all cleared.
- Collision and a pending jump request on the same tick → OVER, no jump started. START asserted during RUN → no effect.
- With `DINO_HIGHSCORE_EN`: crash at 0042 then at 0017 → `high_score`=0042. RESET → 0. Without the macro → `high_score`=0 throughout.
